// File: rtl/vme_request_decode_if.sv
// CPU-side strobe/address inputs and VME request/status outputs of the
// request decoder, bundled so the decoder and its driver share one port list.
interface vme_request_decode_if;
    logic        cpu_as;
    logic [31:0] cpu_address;
    logic [2:0]  cpu_fc;
    logic        request_vme;
    logic        request_vme_a16;
    logic        request_vme_a24;
    logic        request_vme_a40;
    logic        timeout_active;
    logic [7:0]  timeout_count;

    modport master (
        output cpu_as, cpu_address, cpu_fc,
        input  request_vme, request_vme_a16, request_vme_a24, request_vme_a40,
        input  timeout_active, timeout_count
    );

    modport slave (
        input  cpu_as, cpu_address, cpu_fc,
        output request_vme, request_vme_a16, request_vme_a24, request_vme_a40,
        output timeout_active, timeout_count
    );
endinterface

// File: rtl/vme_request_decode.sv
// Synchronises the CPU address strobe, decodes address/function code into
// active-low VME window requests, and withdraws them when the bus watchdog expires.
module vme_request_decode #(
    parameter logic [15:0] A16_PREFIX     = 16'hFFFF,
    parameter logic [7:0]  A24_PREFIX     = 8'hFF,
    parameter logic [3:0]  A40_PREFIX     = 4'h8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic                 clock,
    input  logic                 reset,
    vme_request_decode_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, VME, LOCAL, TIMEOUT} state_t;
    typedef enum logic [1:0] {WIN_NONE, WIN_A16, WIN_A24, WIN_A40} window_t;

    logic        as_s1, as_s2;
    state_t      state, state_next;
    window_t     window, window_next, hit;
    logic [15:0] wd_count, wd_count_next;
    logic [7:0]  to_count, to_count_next;
    logic        in_vme;

    // CPU space (fc 111) never reaches VME regardless of address.
    function automatic window_t decode_window(input logic [31:0] address,
                                              input logic [2:0]  fc);
        window_t w;
        w = WIN_NONE;
        if (fc != 3'b111) begin
            if (address[31:16] == A16_PREFIX)
                w = WIN_A16;
            else if (address[31:24] == A24_PREFIX)
                w = WIN_A24;
            else if (address[31:28] == A40_PREFIX)
                w = WIN_A40;
        end
        return w;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            as_s1    <= 1'b1;
            as_s2    <= 1'b1;
            state    <= IDLE;
            window   <= WIN_NONE;
            wd_count <= 16'd0;
            to_count <= 8'd0;
        end else begin
            as_s1    <= bus.cpu_as;
            as_s2    <= as_s1;
            state    <= state_next;
            window   <= window_next;
            wd_count <= wd_count_next;
            to_count <= to_count_next;
        end
    end

    // Address and fc are only looked at once as_s2 shows the strobe low,
    // by which point they have been stable for two clocks.
    always_comb begin
        state_next    = state;
        window_next   = window;
        wd_count_next = wd_count;
        to_count_next = to_count;
        hit           = decode_window(bus.cpu_address, bus.cpu_fc);

        case (state)
            IDLE: begin
                if (!as_s2) begin
                    if (hit != WIN_NONE) begin
                        state_next    = VME;
                        window_next   = hit;
                        wd_count_next = 16'd0;
                    end else begin
                        state_next = LOCAL;
                    end
                end
            end
            VME: begin
                // A strobe release seen on the expiry edge ends the cycle normally.
                if (as_s2) begin
                    state_next = IDLE;
                end else if (wd_count == TIMEOUT_CYCLES - 16'd1) begin
                    state_next    = TIMEOUT;
                    to_count_next = sat_inc8(to_count);
                end else begin
                    wd_count_next = wd_count + 16'd1;
                end
            end
            LOCAL: begin
                if (as_s2)
                    state_next = IDLE;
            end
            TIMEOUT: begin
                if (as_s2)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs derive only from registers, so each changes exactly on a state edge.
    assign in_vme              = (state == VME);
    assign bus.request_vme     = !in_vme;
    assign bus.request_vme_a16 = !(in_vme && window == WIN_A16);
    assign bus.request_vme_a24 = !(in_vme && window == WIN_A24);
    assign bus.request_vme_a40 = !(in_vme && window == WIN_A40);
    assign bus.timeout_active  = (state != TIMEOUT);
    assign bus.timeout_count   = to_count;

endmodule

// File: doc/vme_request_decode.md
# vme_request_decode

Upstream stage of the VME data-transfer engine: it watches the CPU bus, synchronises the asynchronous address strobe, and decodes address plus function code into the active-low VME request lines (`request_vme`, `request_vme_a16`, `request_vme_a24`, `request_vme_a40`) that the transfer engine consumes. It also runs a bus watchdog. When a decoded VME cycle outlives its timeout, the block withdraws the requests, which makes the transfer engine terminate the CPU cycle with bus error. A saturating count of timeouts is kept for status.

## Interface
Parameters:
- `A16_PREFIX`, 16'hFFFF, match value for `cpu_address[31:16]` selecting the A16 window
- `A24_PREFIX`, 8'hFF, match value for `cpu_address[31:24]` selecting the A24 window (A16 match takes priority)
- `A40_PREFIX`, 4'h8, match value for `cpu_address[31:28]` selecting the A40 window
- `TIMEOUT_CYCLES`, 16'd1024, clock cycles a VME request may stay asserted; legal range 2..65535

Ports (all CPU/VME control signals active-low):
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `cpu_as`  in  1  CPU address strobe, asynchronous to `clock`
- `cpu_address`  in  32  CPU address, stable while `cpu_as` is low
- `cpu_fc`  in  3  CPU function code, stable while `cpu_as` is low
- `request_vme`  out  1  any VME window hit, cycle live
- `request_vme_a16`  out  1  A16 window hit
- `request_vme_a24`  out  1  A24 window hit
- `request_vme_a40`  out  1  A40 window hit
- `timeout_active`  out  1  low while the current cycle is in timeout
- `timeout_count`  out  8  saturating count of timeouts since reset

## Operation
- `cpu_as` passes through a 2-flop synchroniser (`as_s1`, `as_s2`), reset to 1. `cpu_address` and `cpu_fc` are not synchronised; they are sampled only when `as_s2` is low.
- Decode priority: A16 > A24 > A40 > none. `cpu_fc == 3'b111` (CPU space) always decodes as none.
- States are IDLE, VME, LOCAL, TIMEOUT.
- IDLE: all request outputs are 1. When `as_s2 == 0`:
  - hit: go to VME, drive `request_vme = 0` and exactly one window line to 0, clear the watchdog counter.
  - no hit: go to LOCAL.
- VME:
  - Requests are held constant. The counter increments each cycle.
  - `as_s2 == 1`: go to IDLE and release all requests.
  - Else, if counter reaches `TIMEOUT_CYCLES-1`: go to TIMEOUT, set all requests to 1, `timeout_active = 0`, `timeout_count` += 1 (saturates at 255).
- LOCAL: no outputs change. Go to IDLE when `as_s2 == 1`. No re-decode happens inside one strobe.
- TIMEOUT: requests stay 1 and `timeout_active` stays 0. When `as_s2 == 1`, go to IDLE and set `timeout_active = 1`.
- Exactly one window line is low whenever `request_vme` is low. No window line is ever low while `request_vme` is high.
- Watchdog counter is 16 bits. It is cleared on VME entry and does not wrap within a cycle.
- Reset values: state IDLE; `request_vme`, `request_vme_a16`, `request_vme_a24`, `request_vme_a40` = 1; `timeout_active` = 1; `timeout_count` = 0; counter 0; `as_s1`, `as_s2` = 1.
- Reset mid-cycle: all outputs return to reset values on the next edge. If `cpu_as` is still low after reset releases, the cycle is decoded afresh as a new cycle.

## Timing
- Request assertion: on the 3rd rising edge after `cpu_as` falls (2 synchroniser stages + 1 state register).
- Request release on normal end: on the 3rd rising edge after `cpu_as` rises.
- Timeout fires `TIMEOUT_CYCLES` edges after request assertion. Requests go high on that edge.
- If `as_s2` rises on the same edge that the counter reaches `TIMEOUT_CYCLES-1`, the normal end wins: no timeout, count unchanged.
- Back-to-back cycles: `cpu_as` must be high for at least 2 clocks. A new decode needs IDLE to observe `as_s2 == 0` again.

## Test plan
- A24 read: `cpu_as` low, addr 0xFF12_3456, fc 101 -> `request_vme` and `request_vme_a24` = 0 on the 3rd edge; release 3 edges after `cpu_as` high; `timeout_count` = 0.
- Priority: addr 0xFFFF_0010 -> only `request_vme_a16` low. Addr 0x8000_0000 -> only `request_vme_a40` low. Addr 0x0000_1000 -> nothing low (LOCAL).
- CPU space: addr 0xFFFF_FFF0 with fc 111 -> no request for the whole strobe.
- Timeout with `TIMEOUT_CYCLES = 16` and `cpu_as` held low for 40 clocks -> requests high 16 edges after assertion; `timeout_active` low until 3 edges after `cpu_as` rises; `timeout_count` = 1.
- Saturation: 260 consecutive timeouts -> `timeout_count` stays 255.
- Reset: `reset` pulsed mid-VME-cycle -> all outputs at reset values next edge. With `cpu_as` still low, the cycle is decoded again and requests re-assert 3 edges after reset deasserts.
